// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// Also provides the baud-tick arithmetic used to size the bit and half-bit periods.
package uart_pkg;

    // 16 bits covers BIT_TICKS down to roughly 800 baud at a 50 MHz clock.
    localparam int TIMER_W = 16;

    typedef logic [TIMER_W-1:0] timer_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Clocks per bit, or per half bit when i_half is set; integer division throughout.
    function automatic timer_t baud_ticks(input int unsigned i_clk_freq,
                                          input int unsigned i_baud,
                                          input logic        i_half);
        int unsigned bit_ticks;
        bit_ticks = i_clk_freq / i_baud;
        return i_half ? timer_t'(bit_ticks / 2) : timer_t'(bit_ticks);
    endfunction

endpackage

// File: rtl/uart_rx_counter.sv
// Baud timer: counts up while enabled, pulses o_ovf on the last count of an
// i_limit-cycle period and wraps to zero; held at zero while disabled.
module uart_rx_counter
    import uart_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_enable,
    input  logic [TIMER_W-1:0] i_limit,
    output logic [TIMER_W-1:0] o_count,
    output logic               o_ovf
);

    logic [TIMER_W-1:0] r_count;

    assign o_ovf   = i_enable && (r_count == i_limit - TIMER_W'(1));
    assign o_count = r_count;

    // NOTE: state registers use non-blocking assignments and the async reset
    // sits in the sensitivity list so it acts without waiting for a clock.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (!i_enable || o_ovf) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + TIMER_W'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop line synchronizer, mid-bit sampling FSM, optional even
// parity; each word is delivered with a one-cycle rx_valid plus error flags.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int DATA_WIDTH = 8,
    parameter int PARITY_EN  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam logic [TIMER_W-1:0] BIT_TICKS  = baud_ticks(CLK_FREQ, BAUD, FALSE);
    localparam logic [TIMER_W-1:0] HALF_TICKS = baud_ticks(CLK_FREQ, BAUD, TRUE);
    localparam logic [3:0]         LAST_IDX   = 4'(DATA_WIDTH - 1);

    logic                  r_rx_meta;
    logic                  r_rx_s;
    rx_state_t             r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [3:0]            r_bit_idx;
    logic                  r_par_err;

    logic                  w_timer_en;
    logic                  w_ovf;
    logic [TIMER_W-1:0]    w_timer_limit;
    logic [TIMER_W-1:0]    w_timer_count_unused;

    // NOTE: both synchronizer flops reset to 1 so the idle-high line is not
    // mistaken for a start bit while the flops fill after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // The timer runs continuously from the start bit to the stop sample, so
    // switching from the half-bit to the full-bit period keeps samples centred.
    assign w_timer_en    = (r_state == START) || (r_state == DATA) ||
                           (r_state == PARITY) || (r_state == STOP);
    assign w_timer_limit = (r_state == START) ? HALF_TICKS : BIT_TICKS;
    assign busy          = (r_state != IDLE);

    uart_rx_counter u_baud_timer (
        .clk      (clk),
        .rst      (rst),
        .i_enable (w_timer_en),
        .i_limit  (w_timer_limit),
        .o_count  (w_timer_count_unused),
        .o_ovf    (w_ovf)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_par_err  <= FALSE;
            rx_data    <= '0;
            rx_valid   <= FALSE;
            parity_err <= FALSE;
            frame_err  <= FALSE;
        end else begin
            rx_valid <= FALSE;
            case (r_state)
                IDLE: begin
                    if (!r_rx_s) r_state <= START;
                end
                START: begin
                    if (w_ovf) begin
                        if (r_rx_s) begin
                            r_state <= IDLE;
                        end else begin
                            r_state   <= DATA;
                            r_bit_idx <= '0;
                        end
                    end
                end
                DATA: begin
                    if (w_ovf) begin
                        r_shift   <= {r_rx_s, r_shift[DATA_WIDTH-1:1]};
                        r_bit_idx <= r_bit_idx + 4'd1;
                        if (r_bit_idx == LAST_IDX) begin
                            r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (w_ovf) begin
                        r_par_err <= (^r_shift) ^ r_rx_s;
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    // Error frames still strobe; the consumer qualifies on the flags.
                    if (w_ovf) begin
                        rx_valid   <= TRUE;
                        rx_data    <= r_shift;
                        parity_err <= (PARITY_EN != 0) ? r_par_err : FALSE;
                        frame_err  <= !r_rx_s;
                        r_state    <= r_rx_s ? IDLE : WAIT_IDLE;
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line (break) must go high before a new start is armed.
                    if (r_rx_s) r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames for uart_rx, checked against a frame-level
// model: expected word, error flags and the strobe cycle derived from bit timing.
module tb_uart_rx;

    localparam int CLK_FREQ = 50000000;
    localparam int BAUD     = 115200;
    localparam int DW       = 8;
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int HALF     = BIT / 2;
    localparam int SYNC_LAT = 2;
    // Stop bit is the 11th bit (index 10); strobe follows the stop sample by one cycle.
    localparam int STROBE_OFS = SYNC_LAT + HALF + (1 + DW + 1) * BIT + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx  = 1'b1;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          parity_err;
    logic          frame_err;
    logic          busy;

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .DATA_WIDTH (DW),
        .PARITY_EN  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #10 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
        logic          ferr;
        longint        at;
    } frame_t;

    frame_t exp_q[$];
    frame_t got_q[$];

    logic [DW-1:0] m_data = '0;
    logic          m_perr = 1'b0;
    logic          m_ferr = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always @(negedge clk) begin
        frame_t f;
        if (rx_valid === 1'b1) begin
            f.data = rx_data;
            f.perr = parity_err;
            f.ferr = frame_err;
            f.at   = cyc;
            got_q.push_back(f);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Advance n clocks and land just after the edge, where outputs are settled.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        idle(BIT);
    endtask

    task automatic model_frame(input longint k, input logic [DW-1:0] d, input logic p, input logic s);
        frame_t f;
        f.data = d;
        f.perr = (($countones(d) + int'(p)) % 2) != 0;
        f.ferr = (s == 1'b0);
        f.at   = k + STROBE_OFS;
        exp_q.push_back(f);
        m_data = f.data;
        m_perr = f.perr;
        m_ferr = f.ferr;
    endtask

    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s);
        model_frame(cyc, d, p, s);
        send_bit(1'b0);
        for (int i = 0; i < DW; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    task automatic compare_results(input string tag);
        check($sformatf("%s.count", tag), 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s[%0d].data", tag, i), 64'(got_q[i].data), 64'(exp_q[i].data));
            check($sformatf("%s[%0d].perr", tag, i), 64'(got_q[i].perr), 64'(exp_q[i].perr));
            check($sformatf("%s[%0d].ferr", tag, i), 64'(got_q[i].ferr), 64'(exp_q[i].ferr));
            check($sformatf("%s[%0d].cycle", tag, i), 64'(got_q[i].at), 64'(exp_q[i].at));
        end
        check($sformatf("%s.held_data", tag), 64'(rx_data), 64'(m_data));
        check($sformatf("%s.held_perr", tag), 64'(parity_err), 64'(m_perr));
        check($sformatf("%s.held_ferr", tag), 64'(frame_err), 64'(m_ferr));
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        longint k;
        logic [DW-1:0] d;
        logic [DW-1:0] c3;
        logic p;

        // Reset state
        idle(3);
        check("reset.rx_data", 64'(rx_data), 64'(0));
        check("reset.rx_valid", 64'(rx_valid), 64'(0));
        check("reset.parity_err", 64'(parity_err), 64'(0));
        check("reset.frame_err", 64'(frame_err), 64'(0));
        check("reset.busy", 64'(busy), 64'(0));
        rst = 1'b1;
        idle(10);

        // 1. Good frame
        send_frame(8'hA5, 1'b0, 1'b1);
        idle(20);
        compare_results("good_a5");

        // 2. Glitch shorter than half a bit
        k = cyc;
        rx = 1'b0;
        idle(100);
        rx = 1'b1;
        idle(HALF + SYNC_LAT - 100);
        check("glitch.busy_before_mid", 64'(busy), 64'(1));
        check("glitch.cycle", 64'(cyc - k), 64'(HALF + SYNC_LAT));
        idle(1);
        check("glitch.busy_after_mid", 64'(busy), 64'(0));
        idle(50);
        compare_results("glitch");

        // 3. Parity error, then a clean frame clears it
        send_frame(8'h3C, 1'b1, 1'b1);
        idle(20);
        send_frame(8'h00, 1'b0, 1'b1);
        idle(20);
        compare_results("parity");

        // 4. Framing error followed by a break
        send_frame(8'h55, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            idle(500);
            check($sformatf("break.busy%0d", i), 64'(busy), 64'(1));
        end
        rx = 1'b1;
        idle(10);
        check("break.busy_released", 64'(busy), 64'(0));
        compare_results("break");
        send_frame(8'h81, 1'b0, 1'b1);
        idle(20);
        compare_results("after_break");

        // 5. Back-to-back frames with no idle gap
        send_frame(8'h01, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_frame(8'h80, 1'b1, 1'b1);
        idle(20);
        if (got_q.size() == 3) begin
            check("b2b.spacing01", 64'(got_q[1].at - got_q[0].at), 64'((1 + DW + 2) * BIT));
            check("b2b.spacing12", 64'(got_q[2].at - got_q[1].at), 64'((1 + DW + 2) * BIT));
        end
        compare_results("b2b");

        // 6. Reset during data bit 4
        c3 = 8'hC3;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(c3[i]);
        rx = c3[4];
        idle(200);
        rst = 1'b0;
        #1;
        m_data = '0;
        m_perr = 1'b0;
        m_ferr = 1'b0;
        check("midrst.rx_data", 64'(rx_data), 64'(0));
        check("midrst.rx_valid", 64'(rx_valid), 64'(0));
        check("midrst.parity_err", 64'(parity_err), 64'(0));
        check("midrst.frame_err", 64'(frame_err), 64'(0));
        check("midrst.busy", 64'(busy), 64'(0));
        rx = 1'b1;
        idle(5);
        rst = 1'b1;
        idle(20);
        send_frame(8'h3A, 1'b0, 1'b1);
        idle(20);
        compare_results("after_reset");

        // Randomized frames: random data, occasionally wrong parity, random gaps
        for (int n = 0; n < 3; n++) begin
            d = DW'($urandom_range(0, 255));
            p = (^d) ^ ($urandom_range(0, 3) == 0);
            send_frame(d, p, 1'b1);
            idle($urandom_range(0, 40));
        end
        idle(20);
        compare_results("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
